// File: rtl/psum_in_router_fifo.sv
// psum_in_router_fifo: routes upstream chain psums, buffered (sign-extended)
// bus words, or their sum into a PE's psum input through a registered
// valid/ready output stage.
module psum_in_router_fifo #(
  parameter int DATA_WIDTH      = 16,
  parameter int PSUM_DATA_WIDTH = 48,
  parameter int ID_WIDTH        = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         config_state,
  input  logic                         ce,
  input  logic [ID_WIDTH-1:0]          dest_id,
  input  logic [1:0]                   cfg_mode,
  input  logic [ID_WIDTH-1:0]          source_id,
  input  logic [DATA_WIDTH-1:0]        bus_data_in,
  input  logic                         bus_data_valid,
  output logic                         pe_ready,
  input  logic [PSUM_DATA_WIDTH-1:0]   last_pe_data_in,
  input  logic                         last_pe_data_valid,
  output logic                         last_pe_data_ready,
  output logic [PSUM_DATA_WIDTH-1:0]   pe_psum_in,
  output logic                         pe_psum_in_en,
  input  logic                         pe_psum_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] MODE_CHAIN = 2'b01;
  localparam logic [1:0] MODE_BUS   = 2'b10;
  localparam logic [1:0] MODE_ACC   = 2'b11;

  logic [ID_WIDTH-1:0]        stored_id_q, stored_id_d;
  logic [1:0]                 mode_q, mode_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [PSUM_DATA_WIDTH-1:0] psum_q, psum_d;
  logic                       en_q, en_d;
  logic [PSUM_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                       run_s, cfg_s, id_match_s, out_free_s;
  logic                       fifo_full_s, fifo_empty_s;
  logic                       pe_ready_s, push_s, pop_s, load_s, chain_rdy_s;
  logic [PSUM_DATA_WIDTH-1:0] ext_s, head_s, load_val_s;
  logic                       unused_id_lsb_s;

  // The ID LSB selects a PE within a pair; only the upper bits name the bus target.
  assign unused_id_lsb_s = stored_id_q[0];

  assign run_s        = ce && !config_state;
  assign cfg_s        = ce && config_state;
  assign id_match_s   = ({1'b0, stored_id_q[ID_WIDTH-1:1]} == source_id);
  assign out_free_s   = !en_q || pe_psum_ready;
  assign fifo_full_s  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  assign ext_s        = PSUM_DATA_WIDTH'($signed(bus_data_in));
  assign head_s       = mem_q[rd_ptr_q];

  // A full FIFO refuses the bus even when a pop happens in the same cycle.
  assign pe_ready_s = run_s && id_match_s && mode_q[1] && !fifo_full_s;
  assign push_s     = pe_ready_s && bus_data_valid;

  assign pe_ready           = pe_ready_s;
  assign last_pe_data_ready = chain_rdy_s;
  assign pe_psum_in         = psum_q;
  assign pe_psum_in_en      = en_q;
  assign fifo_count         = count_q;

  // Mode decode: chain ready, FIFO pop, and the value loaded into the output stage
  always_comb begin
    chain_rdy_s = 1'b0;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    load_val_s  = psum_q;
    case (mode_q)
      MODE_CHAIN: begin
        chain_rdy_s = run_s && out_free_s;
        load_s      = chain_rdy_s && last_pe_data_valid;
        load_val_s  = last_pe_data_in;
      end
      MODE_BUS: begin
        load_s     = run_s && out_free_s && !fifo_empty_s;
        pop_s      = load_s;
        load_val_s = head_s;
      end
      MODE_ACC: begin
        chain_rdy_s = run_s && out_free_s && !fifo_empty_s;
        load_s      = chain_rdy_s && last_pe_data_valid;
        pop_s       = load_s;
        load_val_s  = head_s + last_pe_data_in;
      end
      default: begin
        chain_rdy_s = 1'b0;
        pop_s       = 1'b0;
        load_s      = 1'b0;
        load_val_s  = psum_q;
      end
    endcase
  end

  // Next-state: config capture and flush, otherwise FIFO bookkeeping and output load
  always_comb begin
    stored_id_d = stored_id_q;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    psum_d      = psum_q;
    en_d        = en_q;
    if (cfg_s) begin
      stored_id_d = dest_id;
      mode_d      = cfg_mode;
      wr_ptr_d    = {PTR_W{1'b0}};
      rd_ptr_d    = {PTR_W{1'b0}};
      count_d     = {CNT_W{1'b0}};
      en_d        = 1'b0;
    end else if (run_s) begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
      if (load_s) begin
        psum_d = load_val_s;
        en_d   = 1'b1;
      end else if (pe_psum_ready) begin
        en_d = 1'b0;
      end else begin
        en_d = en_q;
      end
    end else begin
      en_d = en_q;
    end
  end

  // Control and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stored_id_q <= {ID_WIDTH{1'b0}};
      mode_q      <= 2'b00;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      psum_q      <= {PSUM_DATA_WIDTH{1'b0}};
      en_q        <= 1'b0;
    end else begin
      stored_id_q <= stored_id_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      psum_q      <= psum_d;
      en_q        <= en_d;
    end
  end

  // FIFO storage: written on push, cleared on reset so no stale data survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {PSUM_DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= ext_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_psum_in_router_fifo.sv
// Testbench for psum_in_router_fifo: vector table, directed corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_psum_in_router_fifo;
  localparam int DW = 16;
  localparam int PW = 48;
  localparam int IW = 8;
  localparam int FD = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          config_state = 1'b0;
  logic          ce = 1'b0;
  logic [IW-1:0] dest_id = '0;
  logic [1:0]    cfg_mode = 2'b00;
  logic [IW-1:0] source_id = '0;
  logic [DW-1:0] bus_data_in = '0;
  logic          bus_data_valid = 1'b0;
  logic          pe_ready;
  logic [PW-1:0] last_pe_data_in = '0;
  logic          last_pe_data_valid = 1'b0;
  logic          last_pe_data_ready;
  logic [PW-1:0] pe_psum_in;
  logic          pe_psum_in_en;
  logic          pe_psum_ready = 1'b0;
  logic [CW-1:0] fifo_count;

  psum_in_router_fifo #(
    .DATA_WIDTH(DW), .PSUM_DATA_WIDTH(PW), .ID_WIDTH(IW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .config_state(config_state), .ce(ce),
    .dest_id(dest_id), .cfg_mode(cfg_mode), .source_id(source_id),
    .bus_data_in(bus_data_in), .bus_data_valid(bus_data_valid), .pe_ready(pe_ready),
    .last_pe_data_in(last_pe_data_in), .last_pe_data_valid(last_pe_data_valid),
    .last_pe_data_ready(last_pe_data_ready), .pe_psum_in(pe_psum_in),
    .pe_psum_in_en(pe_psum_in_en), .pe_psum_ready(pe_psum_ready), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: FIFO as a queue, output stage as value + valid flag.
  logic [PW-1:0] m_q[$];
  logic [IW-1:0] m_id;
  logic [1:0]    m_mode;
  logic [PW-1:0] m_out;
  logic          m_en;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] bus;
    logic [PW-1:0] chain;
    logic [PW-1:0] exp;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_id   = '0;
    m_mode = 2'b00;
    m_out  = '0;
    m_en   = 1'b0;
  endtask

  // Readies the model expects from the current inputs and model state.
  function automatic void m_ready(output logic pr, output logic cr);
    logic run, free;
    run  = ce && !config_state;
    free = !m_en || pe_psum_ready;
    pr = run && (source_id == (m_id >> 1)) && m_mode[1] && (m_q.size() < FD);
    cr = run && free && ((m_mode == 2'b01) || (m_mode == 2'b11 && m_q.size() > 0));
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic m_edge();
    logic pr, cr, load, free;
    logic [PW-1:0] val;
    m_ready(pr, cr);
    free = !m_en || pe_psum_ready;
    if (ce && config_state) begin
      m_id   = dest_id;
      m_mode = cfg_mode;
      m_q.delete();
      m_en   = 1'b0;
    end else if (ce) begin
      load = 1'b0;
      val  = m_out;
      if (m_mode == 2'b01 && cr && last_pe_data_valid) begin
        load = 1'b1; val = last_pe_data_in;
      end else if (m_mode == 2'b10 && free && m_q.size() > 0) begin
        load = 1'b1; val = m_q.pop_front();
      end else if (m_mode == 2'b11 && cr && last_pe_data_valid) begin
        load = 1'b1; val = m_q.pop_front() + last_pe_data_in;
      end
      if (pr && bus_data_valid) m_q.push_back({{(PW-DW){bus_data_in[DW-1]}}, bus_data_in});
      if (load) begin
        m_out = val; m_en = 1'b1;
      end else if (pe_psum_ready) begin
        m_en = 1'b0;
      end
    end
  endtask

  // One clock: check readies before the edge, registered outputs after it.
  task automatic cycle();
    logic pr, cr;
    #1;
    m_ready(pr, cr);
    chk("pe_ready", 64'(pe_ready), 64'(pr));
    chk("last_pe_data_ready", 64'(last_pe_data_ready), 64'(cr));
    m_edge();
    @(posedge clk);
    #1;
    chk("pe_psum_in_en", 64'(pe_psum_in_en), 64'(m_en));
    if (m_en) chk("pe_psum_in", 64'(pe_psum_in), 64'(m_out));
    chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
  endtask

  task automatic configure(input logic [IW-1:0] id, input logic [1:0] md);
    config_state = 1'b1; ce = 1'b1; dest_id = id; cfg_mode = md;
    bus_data_valid = 1'b0; last_pe_data_valid = 1'b0;
    cycle();
    config_state = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    bus_data_valid = 1'b1; bus_data_in = w;
    cycle();
    bus_data_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_psum", 64'(pe_psum_in), 64'h0);
    chk("rst_en", 64'(pe_psum_in_en), 64'h0);
    chk("rst_count", 64'(fifo_count), 64'h0);
    chk("rst_pe_ready", 64'(pe_ready), 64'h0);
    chk("rst_chain_ready", 64'(last_pe_data_ready), 64'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0] got[$];
    vt[0] = '{2'b10, 16'h8001, 48'h0, 48'hFFFF_FFFF_8001};
    vt[1] = '{2'b10, 16'h7FFF, 48'h0, 48'h0000_0000_7FFF};
    vt[2] = '{2'b01, 16'h0000, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC};
    vt[3] = '{2'b11, 16'hFFFF, 48'h0000_0000_0005, 48'h0000_0000_0004};
    vt[4] = '{2'b11, 16'h0001, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000};
    vt[5] = '{2'b11, 16'h8000, 48'h0000_0001_0000, 48'h0000_0000_8000};
    vt[6] = '{2'b11, 16'h0010, 48'h0000_0000_0020, 48'h0000_0000_0030};

    // Reset state
    m_reset();
    reset_pulse();

    // Bus mode latency and sign extension
    configure(8'h0A, 2'b10);
    source_id = 8'h05; pe_psum_ready = 1'b1;
    bus_data_valid = 1'b1; bus_data_in = 16'h8001;
    #1 chk("bus_pe_ready", 64'(pe_ready), 64'h1);
    cycle();
    bus_data_valid = 1'b0;
    chk("bus_lat_first", 64'(pe_psum_in_en), 64'h0);
    cycle();
    chk("bus_lat_second", 64'(pe_psum_in_en), 64'h1);
    chk("bus_sext", 64'(pe_psum_in), 64'hFFFF_FFFF_8001);

    // Vector table: one word per mode, expected output precomputed
    for (int i = 0; i < 7; i++) begin
      configure(8'h0A, vt[i].mode);
      source_id = 8'h05; pe_psum_ready = 1'b1;
      if (vt[i].mode[1]) push_word(vt[i].bus);
      last_pe_data_valid = vt[i].mode[0];
      last_pe_data_in = vt[i].chain;
      cycle();
      last_pe_data_valid = 1'b0;
      chk("vec_en", 64'(pe_psum_in_en), 64'h1);
      chk("vec_out", 64'(pe_psum_in), 64'(vt[i].exp));
    end

    // Fill: 5 words with PE stalled, 4 in FIFO plus 1 held, then drain in order
    configure(8'h0A, 2'b10);
    source_id = 8'h05; pe_psum_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(DW'(k + 1));
    chk("full_count", 64'(fifo_count), 64'h4);
    chk("full_held", 64'(pe_psum_in), 64'h1);
    got.delete();
    pe_psum_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus_data_valid = (c == 0);
      bus_data_in = 16'h0006;
      if (pe_psum_in_en) got.push_back(pe_psum_in);
      if (c == 0) begin
        #1 chk("full_pe_ready_on_pop", 64'(pe_ready), 64'h0);
      end
      cycle();
    end
    bus_data_valid = 1'b0;
    chk("drain_count", 64'(got.size()), 64'h5);
    for (int k = 0; k < 5; k++)
      chk("drain_order", (k < got.size()) ? 64'(got[k]) : 64'hDEAD, 64'(k + 1));

    // Chain pass-through at one-cycle latency, bus refused
    configure(8'h0A, 2'b01);
    source_id = 8'h05; pe_psum_ready = 1'b1;
    bus_data_valid = 1'b1; bus_data_in = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      last_pe_data_valid = 1'b1; last_pe_data_in = PW'(k + 1);
      #1 chk("chain_pe_ready", 64'(pe_ready), 64'h0);
      cycle();
      chk("chain_val", 64'(pe_psum_in), 64'(k + 1));
    end
    last_pe_data_valid = 1'b0; bus_data_valid = 1'b0;

    // Source ID mismatch
    configure(8'h0A, 2'b10);
    source_id = 8'h06; bus_data_valid = 1'b1; bus_data_in = 16'h2222;
    cycle();
    cycle();
    bus_data_valid = 1'b0;
    chk("mismatch_count", 64'(fifo_count), 64'h0);

    // ce low holds a pending output and refuses the bus
    configure(8'h0A, 2'b10);
    source_id = 8'h05; pe_psum_ready = 1'b0;
    push_word(16'h0033);
    cycle();
    ce = 1'b0; pe_psum_ready = 1'b1; bus_data_valid = 1'b1;
    cycle();
    chk("ce_hold_en", 64'(pe_psum_in_en), 64'h1);
    chk("ce_hold_val", 64'(pe_psum_in), 64'h33);
    ce = 1'b1; bus_data_valid = 1'b0;

    // Reconfigure mid-burst flushes FIFO and output valid
    configure(8'h0A, 2'b10);
    source_id = 8'h05; pe_psum_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_word(DW'(k + 7));
    configure(8'h0A, 2'b11);
    chk("recfg_en", 64'(pe_psum_in_en), 64'h0);
    chk("recfg_count", 64'(fifo_count), 64'h0);

    // Reset mid-burst with 3 words queued
    configure(8'h0A, 2'b10);
    source_id = 8'h05; pe_psum_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_word(DW'(k + 9));
    chk("pre_rst_count", 64'(fifo_count), 64'h3);
    reset_pulse();

    // Randomized traffic against the model
    configure(8'h0A, 2'b11);
    for (int n = 0; n < 600; n++) begin
      ce                 = ($urandom_range(0, 9) != 0);
      config_state       = ($urandom_range(0, 39) == 0);
      dest_id            = 8'h0A + IW'($urandom_range(0, 2));
      cfg_mode           = 2'($urandom_range(0, 3));
      source_id          = ($urandom_range(0, 5) == 0) ? 8'h06 : 8'h05;
      bus_data_valid     = $urandom_range(0, 1) == 1;
      bus_data_in        = DW'($urandom);
      last_pe_data_valid = $urandom_range(0, 1) == 1;
      last_pe_data_in    = {16'($urandom), 32'($urandom)};
      pe_psum_ready      = ($urandom_range(0, 3) != 0);
      cycle();
    end
    config_state = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
